// File: rtl/register_file_mp_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
// The top level and its read ports import this package.
package regfile_pkg;

   typedef enum logic {
      RF_SCRUB = 1'b0,
      RF_READY = 1'b1
   } rf_state_t;

   localparam int DEFAULT_REG_SIZE  = 32;
   localparam int DEFAULT_ADDR_SIZE = 4;
   localparam int DEFAULT_NUM_RD    = 2;
   localparam int DEFAULT_PC_INDEX  = 15;

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: PC alias beats write bypass, which beats the array word.
// The output holds when the port is not strobed or the file is still scrubbing.
module register_file_read_port
   import regfile_pkg::*;
#(
   parameter int REG_SIZE  = DEFAULT_REG_SIZE,
   parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
   parameter int HAS_PC    = 1,
   parameter int PC_INDEX  = DEFAULT_PC_INDEX
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 ready,
   input  logic                 rd_en,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   input  logic                 wr_en,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [REG_SIZE-1:0]  wr_data,
   input  logic [REG_SIZE-1:0]  pc_in,
   input  logic [REG_SIZE-1:0]  mem_word,
   output logic [REG_SIZE-1:0]  rd_data
);

   localparam logic [ADDR_SIZE-1:0] PC_ADDR = ADDR_SIZE'(PC_INDEX);

   logic [REG_SIZE-1:0] next_data;

   always_comb begin
      next_data = mem_word;
      if ((HAS_PC != 0) && (rd_addr == PC_ADDR)) begin
         next_data = pc_in;
      end else if (wr_en && (wr_addr == rd_addr)) begin
         next_data = wr_data;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rd_data <= '0;
      end else if (ready && rd_en) begin
         rd_data <= next_data;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Register file with NUM_RD registered read ports, one bypassed write port, optional PC alias.
// Storage has no reset; a scrub FSM zeroes every entry after reset before ready rises.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int REG_SIZE  = DEFAULT_REG_SIZE,
   parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
   parameter int NUM_RD    = DEFAULT_NUM_RD,
   parameter int HAS_PC    = 1,
   parameter int PC_INDEX  = DEFAULT_PC_INDEX
) (
   input  logic                          clk,
   input  logic                          nreset,
   input  logic [NUM_RD-1:0]             rd_en,
   input  logic [NUM_RD*ADDR_SIZE-1:0]   rd_addr,
   output logic [NUM_RD*REG_SIZE-1:0]    rd_data,
   input  logic                          wr_en,
   input  logic [ADDR_SIZE-1:0]          wr_addr,
   input  logic [REG_SIZE-1:0]           wr_data,
   input  logic [REG_SIZE-1:0]           pc_in,
   output logic                          ready
);

   localparam int DEPTH = 2**ADDR_SIZE;
   localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH-1);
   localparam logic [ADDR_SIZE-1:0] PC_ADDR  = ADDR_SIZE'(PC_INDEX);

   rf_state_t            state_q, state_d;
   logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
   logic                 scrub_we;
   logic                 user_we;
   logic [REG_SIZE-1:0]  mem [DEPTH];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= RF_SCRUB;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      scrub_we = 1'b0;
      case (state_q)
         RF_SCRUB: begin
            scrub_we = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = RF_READY;
            end
         end
         RF_READY: begin
            state_d = RF_READY;
         end
         default: begin
            state_d = RF_SCRUB;
         end
      endcase
   end

   assign ready = (state_q == RF_READY);

   // The PC entry belongs to fetch, so writes aimed at it are discarded.
   assign user_we = ready && wr_en && !((HAS_PC != 0) && (wr_addr == PC_ADDR));

   always_ff @(posedge clk) begin
      if (scrub_we) begin
         mem[cnt_q] <= '0;
      end else if (user_we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [REG_SIZE-1:0] mem_word;

      assign mem_word = mem[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]];

      register_file_read_port #(
         .REG_SIZE (REG_SIZE),
         .ADDR_SIZE(ADDR_SIZE),
         .HAS_PC   (HAS_PC),
         .PC_INDEX (PC_INDEX)
      ) u_port (
         .clk     (clk),
         .nreset  (nreset),
         .ready   (ready),
         .rd_en   (rd_en[i]),
         .rd_addr (rd_addr[i*ADDR_SIZE +: ADDR_SIZE]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .pc_in   (pc_in),
         .mem_word(mem_word),
         .rd_data (rd_data[i*REG_SIZE +: REG_SIZE])
      );
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp at default parameters (32-bit, 16 entries, 2 ports, PC at 15).
module tb_register_file_mp;

   logic        clk;
   logic        nreset;
   logic [1:0]  rd_en;
   logic [7:0]  rd_addr;
   logic [63:0] rd_data;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] pc_in;
   logic        ready;

   int checks;
   int failures;

   register_file_mp dut (
      .clk    (clk),
      .nreset (nreset),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .pc_in  (pc_in),
      .ready  (ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset  = 1'b1;
      rd_en   = 2'b00;
      rd_addr = 8'h00;
      wr_en   = 1'b0;
      wr_addr = 4'h0;
      wr_data = 32'h0;
      pc_in   = 32'h0;
      @(posedge clk);
      #3 nreset = 1'b0;
      #1;
      checks++;
      if (rd_data !== 64'h0) begin
         failures++;
         $display("[TB] FAIL reset_rd_data actual=%h expected=%h", rd_data, 64'h0);
      end
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_ready actual=%b expected=0", ready);
      end
      // Attempted write and reads during scrub must be ignored.
      wr_en   = 1'b1;
      wr_addr = 4'd2;
      wr_data = 32'h0000_00AA;
      rd_en   = 2'b11;
      rd_addr = {4'd2, 4'd2};
      tick();
      nreset = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if (ready !== (i == 16)) begin
            failures++;
            $display("[TB] FAIL scrub_ready_edge%0d actual=%b expected=%b", i, ready, (i == 16));
         end
         if (i == 15) begin
            checks++;
            if (rd_data !== 64'h0) begin
               failures++;
               $display("[TB] FAIL scrub_rd_hold actual=%h expected=%h", rd_data, 64'h0);
            end
         end
      end
      wr_en = 1'b0;
      rd_en = 2'b00;
   endtask

   task automatic test_scrub_all(input string tag);
      logic [31:0] exp0, exp1;
      for (int a = 0; a < 16; a++) begin
         rd_en   = 2'b11;
         rd_addr = {4'(15 - a), 4'(a)};
         pc_in   = 32'h1234_0000 | 32'(a);
         tick();
         exp0 = (a == 15) ? (32'h1234_0000 | 32'(a)) : 32'h0;
         exp1 = (a == 0)  ? (32'h1234_0000 | 32'(a)) : 32'h0;
         checks++;
         if (rd_data[31:0] !== exp0) begin
            failures++;
            $display("[TB] FAIL %s_p0_addr%0d actual=%h expected=%h", tag, a, rd_data[31:0], exp0);
         end
         checks++;
         if (rd_data[63:32] !== exp1) begin
            failures++;
            $display("[TB] FAIL %s_p1_addr%0d actual=%h expected=%h", tag, 15 - a, rd_data[63:32], exp1);
         end
      end
      rd_en = 2'b00;
   endtask

   task automatic test_write_read();
      wr_en   = 1'b1;
      wr_addr = 4'd3;
      wr_data = 32'hDEAD_BEEF;
      rd_en   = 2'b00;
      tick();
      wr_en   = 1'b0;
      rd_en   = 2'b11;
      rd_addr = {4'd3, 4'd3};
      tick();
      checks++;
      if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         failures++;
         $display("[TB] FAIL write_read actual=%h expected=%h", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      end
      rd_en = 2'b00;
   endtask

   task automatic test_bypass();
      wr_en   = 1'b1;
      wr_addr = 4'd5;
      wr_data = 32'h1234_5678;
      rd_en   = 2'b10;
      rd_addr = {4'd5, 4'd0};
      tick();
      checks++;
      if (rd_data[63:32] !== 32'h1234_5678) begin
         failures++;
         $display("[TB] FAIL bypass_p1 actual=%h expected=%h", rd_data[63:32], 32'h1234_5678);
      end
      checks++;
      if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
         failures++;
         $display("[TB] FAIL bypass_p0_hold actual=%h expected=%h", rd_data[31:0], 32'hDEAD_BEEF);
      end
      wr_en = 1'b0;
      rd_en = 2'b01;
      rd_addr = {4'd0, 4'd5};
      tick();
      checks++;
      if (rd_data[31:0] !== 32'h1234_5678) begin
         failures++;
         $display("[TB] FAIL bypass_array_p0 actual=%h expected=%h", rd_data[31:0], 32'h1234_5678);
      end
      rd_en = 2'b00;
   endtask

   task automatic test_pc_alias();
      pc_in   = 32'h0000_0108;
      wr_en   = 1'b1;
      wr_addr = 4'd15;
      wr_data = 32'hFFFF_FFFF;
      rd_en   = 2'b10;
      rd_addr = {4'd15, 4'd0};
      tick();
      checks++;
      if (rd_data[63:32] !== 32'h0000_0108) begin
         failures++;
         $display("[TB] FAIL pc_over_bypass actual=%h expected=%h", rd_data[63:32], 32'h0000_0108);
      end
      wr_en   = 1'b0;
      rd_en   = 2'b01;
      rd_addr = {4'd0, 4'd15};
      tick();
      checks++;
      if (rd_data[31:0] !== 32'h0000_0108) begin
         failures++;
         $display("[TB] FAIL pc_read actual=%h expected=%h", rd_data[31:0], 32'h0000_0108);
      end
      pc_in = 32'h0000_010C;
      tick();
      checks++;
      if (rd_data[31:0] !== 32'h0000_010C) begin
         failures++;
         $display("[TB] FAIL pc_reread actual=%h expected=%h", rd_data[31:0], 32'h0000_010C);
      end
      rd_en = 2'b00;
   endtask

   task automatic test_hold();
      logic [3:0]  waddr [3];
      logic [31:0] wval  [3];
      waddr[0] = 4'd3; wval[0] = 32'h1111_1111;
      waddr[1] = 4'd5; wval[1] = 32'h5555_5555;
      waddr[2] = 4'd7; wval[2] = 32'h7777_7777;
      rd_en   = 2'b11;
      rd_addr = {4'd5, 4'd3};
      tick();
      rd_en   = 2'b00;
      rd_addr = {4'd1, 4'd0};
      for (int k = 0; k < 3; k++) begin
         wr_en   = 1'b1;
         wr_addr = waddr[k];
         wr_data = wval[k];
         tick();
         checks++;
         if (rd_data !== {32'h1234_5678, 32'hDEAD_BEEF}) begin
            failures++;
            $display("[TB] FAIL hold_cycle%0d actual=%h expected=%h", k, rd_data, {32'h1234_5678, 32'hDEAD_BEEF});
         end
      end
      wr_en   = 1'b0;
      rd_en   = 2'b11;
      rd_addr = {4'd5, 4'd3};
      tick();
      checks++;
      if (rd_data !== {32'h5555_5555, 32'h1111_1111}) begin
         failures++;
         $display("[TB] FAIL hold_after_writes actual=%h expected=%h", rd_data, {32'h5555_5555, 32'h1111_1111});
      end
      rd_en = 2'b00;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp0, exp1;
      for (int k = 0; k < 4; k++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(8 + k);
         wr_data = 32'hA000_0000 + 32'(k);
         rd_en   = 2'b11;
         rd_addr = {4'(8 + k), 4'(7 + k)};
         tick();
         exp0 = (k == 0) ? 32'h7777_7777 : (32'hA000_0000 + 32'(k - 1));
         exp1 = 32'hA000_0000 + 32'(k);
         checks++;
         if (rd_data[31:0] !== exp0) begin
            failures++;
            $display("[TB] FAIL b2b_prev%0d actual=%h expected=%h", k, rd_data[31:0], exp0);
         end
         checks++;
         if (rd_data[63:32] !== exp1) begin
            failures++;
            $display("[TB] FAIL b2b_bypass%0d actual=%h expected=%h", k, rd_data[63:32], exp1);
         end
      end
      wr_en = 1'b0;
      rd_en = 2'b00;
   endtask

   task automatic test_reset_mid();
      int edges;
      @(posedge clk);
      #3 nreset = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_reset_ready actual=%b expected=0", ready);
      end
      checks++;
      if (rd_data !== 64'h0) begin
         failures++;
         $display("[TB] FAIL mid_reset_rd_data actual=%h expected=%h", rd_data, 64'h0);
      end
      tick();
      tick();
      nreset = 1'b1;
      edges = 0;
      while (!ready && edges < 40) begin
         tick();
         edges++;
      end
      checks++;
      if (edges !== 16) begin
         failures++;
         $display("[TB] FAIL mid_reset_scrub_edges actual=%0d expected=16", edges);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_scrub_all("scrub");
      test_write_read();
      test_bypass();
      test_pc_alias();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_scrub_all("rescrub");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file for the CPU datapath. It replaces the single-select design with three things:
- NUM_RD independent registered read ports.
- A dedicated write port with write-to-read bypass.
- An optional PC alias register and a post-reset scrub state machine that zeroes the array without an asynchronous reset on storage.

It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- REG_SIZE, 32, data width in bits.
- ADDR_SIZE, 4, address width; depth = 2**ADDR_SIZE.
- NUM_RD, 2, number of read ports (1..4).
- HAS_PC, 1, when 1, index PC_INDEX aliases pc_in.
- PC_INDEX, 15, aliased register index (must be < 2**ADDR_SIZE).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- nreset  in  1  asynchronous, active-low reset.
- rd_en  in  NUM_RD  per-port read strobe.
- rd_addr  in  NUM_RD*ADDR_SIZE  per-port read address; port i uses bits [i*ADDR_SIZE +: ADDR_SIZE].
- rd_data  out  NUM_RD*REG_SIZE  per-port registered read data; same slicing, width REG_SIZE.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_SIZE  write address.
- wr_data  in  REG_SIZE  write data.
- pc_in  in  REG_SIZE  current PC value from fetch; unused when HAS_PC=0.
- ready  out  1  high once scrub is complete; writes and reads are accepted only while high.

## Operation
- FSM, 2 states: SCRUB, READY. Reset state is SCRUB with the scrub counter at 0.
- SCRUB:
  - Each cycle, write 0 to reg[cnt], then increment cnt.
  - On the cycle cnt == 2**ADDR_SIZE-1, perform the last write and go to READY.
  - wr_en and rd_en are ignored; rd_data holds 0; ready=0.
- READY: ready=1 and the FSM stays in READY until reset.
- Write: in READY with wr_en=1, reg[wr_addr] <= wr_data.
  - When HAS_PC=1 and wr_addr==PC_INDEX, the write is dropped because the PC is owned by fetch.
- Read port i, in READY with rd_en[i]=1: rd_data[i] is loaded with the first matching rule:
  1. HAS_PC=1 and rd_addr[i]==PC_INDEX: pc_in, sampled at that edge.
  2. wr_en=1 and wr_addr==rd_addr[i]: wr_data (bypass; the new value, write-first).
  3. Otherwise: reg[rd_addr[i]].
- rd_en[i]=0: rd_data[i] holds its previous value.
- Ports are fully independent. Any number may read the same address in the same cycle, all with the same result.
- Register contents are undefined until scrub completes. No read can observe them before then.

## Timing
- Reset (nreset=0, asynchronous): rd_data=0 on all ports, ready=0, state=SCRUB, cnt=0, effective immediately without waiting for clk. Array contents are not touched by reset.
- Scrub length: exactly 2**ADDR_SIZE clock edges after nreset deasserts. ready is first seen high after edge 2**ADDR_SIZE (16 edges at default).
- Read latency: 1 cycle. rd_data is valid after the posedge that sampled rd_en/rd_addr.
- Write latency: 1 cycle to the array. The bypass makes a same-edge write visible to a same-edge read, so there is no hazard window.
- Reset mid-scrub or mid-operation: return to SCRUB with cnt=0 and restart the full scrub. Partial writes from before reset are not guaranteed.
- Address width: rd_addr and wr_addr are ADDR_SIZE bits, so every value is in range and no out-of-range case exists.

## Structure
- Shared package regfile_pkg holds:
  - state enum rf_state_t {RF_SCRUB, RF_READY};
  - default PC_INDEX constant;
  - the slicing helper width constants.
- One sub-module, register_file_read_port, instantiated NUM_RD times in a generate loop. It contains the priority mux (PC / bypass / array) and the output register with hold and reset.
- The top level holds the array, the write logic, the scrub FSM and the counter.

## Test plan
- Reset/scrub: assert nreset=0 mid-cycle and check that rd_data=0 and ready=0 immediately. Release and check ready=1 exactly after 16 edges. Read all 16 addresses on port 0 and check each is 0 (except 15, which returns pc_in).
- Basic write/read: write reg[3]=0xDEADBEEF. Next cycle read port0 addr3 and port1 addr3; both return 0xDEADBEEF after 1 cycle.
- Bypass: on the same edge write reg[5]=0x12345678 and read port1 addr5; rd_data[1]=0x12345678. The old value 0 must never appear.
- PC alias: set pc_in=0x00000108 and write reg[15]=0xFFFFFFFF. Read addr15 and get 0x00000108; change pc_in to 0x10C and re-read to get 0x10C.
- Hold / ignore: rd_en=0 for 3 cycles while other addresses are written; rd_data stays unchanged. During SCRUB, wr_en=1 to reg[2]=0xAA is ignored, and reg[2] reads 0 after ready.
- Reset mid-operation: after several writes, pulse nreset low for 2 cycles. ready drops at once, the scrub restarts (16 edges), and all registers read 0.
